// File: rtl/drm_pkg.sv
// Shared widths and FSM state encoding for the DRM stream reader.
package drm_pkg;

  localparam int DRM_ADDR_WIDTH = 10;
  localparam int DRM_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } drm_state_t;

endpackage

// File: rtl/drm_rd_fifo.sv
// Return buffer for RAM read data: DEPTH entries, head visible while not empty.
// A push and pop in the same cycle leave the occupancy unchanged.
module drm_rd_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_dat,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_empty    = (r_count == '0);
  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_do_pop   = i_pop && !o_empty;
  assign w_do_push  = i_push && (!w_full || w_do_pop);
  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_count    = r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= f_next(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= f_next(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the head is only observed while the buffer is non-empty.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

endmodule

// File: rtl/drm_stream_reader.sv
// Streams cmd_len consecutive RAM words (address wrapping) starting at cmd_addr.
// First beat RD_LATENCY+1 cycles after accept, then 1 beat/cycle; m_ready stalls issue via buffer credits.
module drm_stream_reader
  import drm_pkg::*;
#(
  parameter int ADDR_WIDTH = DRM_ADDR_WIDTH,
  parameter int DATA_WIDTH = DRM_DATA_WIDTH,
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = RD_LATENCY + 1
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W = $clog2(FIFO_DEPTH + RD_LATENCY + 1) + 1;

  drm_state_t             r_state;
  drm_state_t             w_state_nxt;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [ADDR_WIDTH-1:0]  r_addr_hold;
  logic [ADDR_WIDTH:0]    r_issue_left;
  logic [ADDR_WIDTH:0]    r_beats_left;
  logic [RD_LATENCY-1:0]  r_pipe;
  logic                   r_zero_done;

  logic                   w_accept;
  logic                   w_drained;
  logic                   w_issue;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_empty;
  logic [CNT_W-1:0]       w_count;
  logic [SUM_W-1:0]       w_inflight;
  logic [SUM_W-1:0]       w_credit_used;
  logic [DATA_WIDTH-1:0]  w_head;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      w_inflight = w_inflight + SUM_W'(r_pipe[i]);
    end
  end

  assign w_pop  = !w_empty && m_ready;
  assign w_push = r_pipe[RD_LATENCY-1];

  // A pop this cycle frees its slot before any newly issued read can land.
  assign w_credit_used = SUM_W'(w_count) + w_inflight - SUM_W'(w_pop);
  assign w_issue       = (r_state == READ) && (r_issue_left != '0) &&
                         (w_credit_used < SUM_W'(FIFO_DEPTH));

  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    w_accept    = 1'b0;
    w_drained   = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        w_accept  = cmd_valid;
        if (cmd_valid && (cmd_len != '0)) w_state_nxt = READ;
      end
      READ: begin
        if (w_issue && (r_issue_left == (ADDR_WIDTH+1)'(1))) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if ((w_inflight == '0) && w_empty) begin
          w_drained   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_addr_hold  <= '0;
      r_issue_left <= '0;
      r_beats_left <= '0;
      r_pipe       <= '0;
      r_zero_done  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_zero_done <= w_accept && (cmd_len == '0);
      r_pipe      <= (r_pipe << 1) | RD_LATENCY'(w_issue);
      if (w_accept) begin
        r_addr       <= cmd_addr;
        r_issue_left <= cmd_len;
        r_beats_left <= cmd_len;
      end else begin
        if (w_issue) begin
          r_addr       <= r_addr + ADDR_WIDTH'(1);
          r_addr_hold  <= r_addr;
          r_issue_left <= r_issue_left - (ADDR_WIDTH+1)'(1);
        end
        if (w_pop && (r_beats_left != '0)) begin
          r_beats_left <= r_beats_left - (ADDR_WIDTH+1)'(1);
        end
      end
    end
  end

  drm_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_rd_fifo (
    .i_clk      (rd_clk),
    .i_rst      (rd_rst),
    .i_push     (w_push),
    .i_push_dat (ram_rd_data),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_empty    (w_empty),
    .o_count    (w_count)
  );

  assign ram_rd_addr = w_issue ? r_addr : r_addr_hold;
  assign m_valid     = !w_empty;
  assign m_data      = w_empty ? '0 : w_head;
  assign m_last      = !w_empty && (r_beats_left == (ADDR_WIDTH+1)'(1));
  assign done        = w_drained || r_zero_done;
  assign busy        = (r_state != IDLE) && !w_drained;

endmodule

// File: tb/tb_drm_stream_reader.sv
// Directed bench: two readers (RD_LATENCY 1 and 2) share stimulus, each with its own RAM model.
module tb_drm_stream_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [9:0]  cmd_addr;
  logic [10:0] cmd_len;
  logic        m_ready;

  logic        cmd_ready_a, m_valid_a, m_last_a, busy_a, done_a;
  logic [9:0]  ram_addr_a;
  logic [31:0] ram_data_a, m_data_a;
  logic        cmd_ready_b, m_valid_b, m_last_b, busy_b, done_b;
  logic [9:0]  ram_addr_b;
  logic [31:0] ram_data_b, ram_q_b, m_data_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  drm_stream_reader #(.RD_LATENCY(1)) u_dut_a (
    .rd_clk(clk), .rd_rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_a),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .ram_rd_addr(ram_addr_a), .ram_rd_data(ram_data_a),
    .m_valid(m_valid_a), .m_ready(m_ready), .m_data(m_data_a), .m_last(m_last_a),
    .busy(busy_a), .done(done_a)
  );

  drm_stream_reader #(.RD_LATENCY(2)) u_dut_b (
    .rd_clk(clk), .rd_rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_b),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .ram_rd_addr(ram_addr_b), .ram_rd_data(ram_data_b),
    .m_valid(m_valid_b), .m_ready(m_ready), .m_data(m_data_b), .m_last(m_last_b),
    .busy(busy_b), .done(done_b)
  );

  // RAM contents: data[a] = 0xFFFFFFFF - a
  always @(posedge clk) ram_data_a <= 32'hFFFFFFFF - {22'd0, ram_addr_a};
  always @(posedge clk) begin
    ram_q_b    <= 32'hFFFFFFFF - {22'd0, ram_addr_b};
    ram_data_b <= ram_q_b;
  end

  function automatic logic [31:0] ram_val(input int a);
    int m;
    m = a % 1024;
    if (m < 0) m += 1024;
    return 32'hFFFFFFFF - 32'(m);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns at the falling edge right after the accepting rising edge.
  task automatic send_cmd(input int a, input int l);
    int w;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = 10'(a);
    cmd_len   = 11'(l);
    w = 0;
    while (!(cmd_ready_a && cmd_ready_b) && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("cmd_accept_wait", 64'(w < 200), 64'(1));
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((busy_a || busy_b || m_valid_a || m_valid_b) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    chk("idle_wait", 64'(w < 3000), 64'(1));
  endtask

  task automatic run_stream(input int addr, input int len, input int budget);
    int na, nb, fa, fb, la, lb, da, db;
    na = 0; nb = 0; fa = -1; fb = -1; la = -1; lb = -1; da = 0; db = 0;
    m_ready = 1'b1;
    send_cmd(addr, len);
    for (int c = 0; c < budget; c++) begin
      if (m_valid_a) begin
        chk("a_data", 64'(m_data_a), 64'(ram_val(addr + na)));
        chk("a_last", 64'(m_last_a), 64'(na == len - 1));
        if (fa < 0) fa = c;
        la = c;
        na++;
      end
      if (m_valid_b) begin
        chk("b_data", 64'(m_data_b), 64'(ram_val(addr + nb)));
        chk("b_last", 64'(m_last_b), 64'(nb == len - 1));
        if (fb < 0) fb = c;
        lb = c;
        nb++;
      end
      if (done_a) da++;
      if (done_b) db++;
      @(negedge clk);
    end
    chk("a_beats", 64'(na), 64'(len));
    chk("b_beats", 64'(nb), 64'(len));
    chk("a_first_latency", 64'(fa), 64'(2));
    chk("b_first_latency", 64'(fb), 64'(3));
    chk("a_throughput", 64'(la - fa), 64'(len - 1));
    chk("b_throughput", 64'(lb - fb), 64'(len - 1));
    chk("a_done_count", 64'(da), 64'(1));
    chk("b_done_count", 64'(db), 64'(1));
    chk("a_busy_end", 64'(busy_a), 64'(0));
  endtask

  initial begin
    int idx, lasts, dn, vs, n;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    m_ready   = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready_a), 64'(1));
    chk("rst_m_valid", 64'(m_valid_a), 64'(0));
    chk("rst_m_last", 64'(m_last_a), 64'(0));
    chk("rst_m_data", 64'(m_data_a), 64'(0));
    chk("rst_ram_addr", 64'(ram_addr_a), 64'(0));
    chk("rst_busy", 64'(busy_a), 64'(0));
    chk("rst_done", 64'(done_a), 64'(0));
    chk("rst_b_m_valid", 64'(m_valid_b), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", 64'(cmd_ready_a), 64'(1));

    // Full sweep of all 1024 locations, both latencies
    run_stream(0, 1024, 1040);
    wait_idle();

    // Address wrap 1022 -> 1
    run_stream(1022, 4, 16);
    wait_idle();

    // Stalled consumer: random ready, then 20 cycles low
    m_ready = 1'b1;
    send_cmd(0, 16);
    idx = 0; lasts = 0; dn = 0;
    for (int c = 0; c < 200; c++) begin
      if (c < 10 || (c >= 30 && c < 40)) m_ready = 1'($urandom_range(0, 1));
      else if (c < 30) m_ready = 1'b0;
      else m_ready = 1'b1;
      if (m_valid_a) begin
        if (m_ready) begin
          chk("stall_data", 64'(m_data_a), 64'(ram_val(idx)));
          chk("stall_last", 64'(m_last_a), 64'(idx == 15));
          if (m_last_a) lasts++;
          idx++;
        end else begin
          chk("stall_hold_data", 64'(m_data_a), 64'(ram_val(idx)));
        end
      end
      if (done_a) dn++;
      @(negedge clk);
    end
    m_ready = 1'b1;
    wait_idle();
    chk("stall_beats", 64'(idx), 64'(16));
    chk("stall_last_count", 64'(lasts), 64'(1));
    chk("stall_done_count", 64'(dn), 64'(1));

    // Zero-length command
    send_cmd(5, 0);
    chk("zero_done_pulse", 64'(done_a), 64'(1));
    chk("zero_done_pulse_b", 64'(done_b), 64'(1));
    chk("zero_cmd_ready", 64'(cmd_ready_a), 64'(1));
    chk("zero_busy", 64'(busy_a), 64'(0));
    @(negedge clk);
    chk("zero_done_drop", 64'(done_a), 64'(0));
    chk("zero_cmd_ready_hold", 64'(cmd_ready_a), 64'(1));
    vs = 0;
    for (int c = 0; c < 6; c++) begin
      if (m_valid_a || m_valid_b) vs++;
      @(negedge clk);
    end
    chk("zero_no_valid", 64'(vs), 64'(0));

    // Reset at beat 5 of a 100-beat command
    m_ready = 1'b1;
    send_cmd(0, 100);
    n = 0;
    for (int c = 0; c < 50; c++) begin
      if (m_valid_a) begin
        chk("rstmid_data", 64'(m_data_a), 64'(ram_val(n)));
        n++;
      end
      if (n == 5) break;
      @(negedge clk);
    end
    chk("rstmid_reached_beat5", 64'(n), 64'(5));
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_m_valid", 64'(m_valid_a), 64'(0));
    chk("rstmid_m_valid_b", 64'(m_valid_b), 64'(0));
    chk("rstmid_done", 64'(done_a), 64'(0));
    chk("rstmid_busy", 64'(busy_a), 64'(0));
    chk("rstmid_ram_addr", 64'(ram_addr_a), 64'(0));
    rst = 1'b0;
    dn = 0; vs = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done_a || done_b) dn++;
      if (m_valid_a || m_valid_b) vs++;
    end
    chk("rstmid_no_done", 64'(dn), 64'(0));
    chk("rstmid_no_beats", 64'(vs), 64'(0));
    chk("rstmid_cmd_ready", 64'(cmd_ready_a), 64'(1));
    run_stream(10, 2, 12);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/drm_stream_reader.md
DRM_STREAM_READER -- requirements
Module: drm_stream_reader

Interface
REQ-001 Parameter ADDR_WIDTH, default 10: width of the RAM read address.
REQ-002 Parameter DATA_WIDTH, default 32: width of the RAM read data and the stream data.
REQ-003 Parameter RD_LATENCY, default 1: cycles from address to data; 1 without the RAM output register, 2 with it. Legal values are 1 and 2.
REQ-004 Parameter FIFO_DEPTH, default RD_LATENCY+1: depth of the internal return buffer.
REQ-005 rd_clk  input  1  sole clock; one clock, all logic on its rising edge.
REQ-006 rd_rst  input  1  reset; synchronous, active-high.
REQ-007 cmd_valid  input  1  read command present.
REQ-008 cmd_ready  output  1  command accepted when high together with cmd_valid.
REQ-009 cmd_addr  input  ADDR_WIDTH  start address.
REQ-010 cmd_len  input  ADDR_WIDTH+1  beat count, 0 to 1024.
REQ-011 ram_rd_addr  output  ADDR_WIDTH  connects to the RAM rd_addr port.
REQ-012 ram_rd_data  input  DATA_WIDTH  connects to the RAM rd_data port.
REQ-013 m_valid, m_ready, m_data[DATA_WIDTH-1:0], m_last  stream output; data moves on a cycle where m_valid and m_ready are both high.
REQ-014 busy  output  1  high from command accept until the last beat transfers.
REQ-015 done  output  1  one-cycle pulse when a command completes.

Function
REQ-016 FSM states:
- IDLE: cmd_ready=1.
- READ: issuing addresses.
- DRAIN: all addresses issued, waiting for the buffer to empty.
REQ-017 IDLE->READ on cmd_valid with cmd_len!=0. Latch the address counter to cmd_addr and the remaining-issue count to cmd_len.
REQ-018 IDLE with cmd_valid and cmd_len==0: the command is accepted, no beats are produced, done pulses on the next cycle, and the FSM stays in IDLE.
REQ-019 Issue rule: one address per cycle, only when (buffer occupancy + reads in flight) < FIFO_DEPTH. On issue, the address increments modulo 2**ADDR_WIDTH (1023 wraps to 0) and the remaining count decrements.
REQ-020 ram_rd_addr shows the issued address in the issue cycle. When not issuing, it holds its last value.
REQ-021 Read data is captured into the buffer exactly RD_LATENCY cycles after issue, using a RD_LATENCY-deep valid shift register.
REQ-022 READ->DRAIN when the remaining count reaches 0. DRAIN->IDLE when in-flight and occupancy both reach 0 after the final transfer; done pulses in that same cycle.
REQ-023 m_valid = buffer not empty. m_data is the buffer head and is held stable while m_valid=1 and m_ready=0.
REQ-024 m_last is high only on the final beat of the command.
REQ-025 Under permanent m_ready=1, throughput is 1 beat/cycle after the first beat. First beat latency from command accept is RD_LATENCY+1 cycles.
REQ-026 A buffer push and pop in the same cycle keep occupancy unchanged. The buffer never overflows; the issue rule guarantees this.
REQ-027 cmd_ready=0 in READ and DRAIN. A command presented there is not accepted and waits.
REQ-028 The beat counter is ADDR_WIDTH+1 bits so that cmd_len=1024 reads all locations exactly once.

Reset
REQ-029 On rd_rst, regardless of state: FSM=IDLE, buffer and in-flight pipe emptied, and the following outputs take these values:
- cmd_ready=1 (effective the cycle after rd_rst deasserts)
- m_valid=0, m_last=0, m_data=0
- ram_rd_addr=0
- busy=0, done=0
REQ-030 Reset mid-transfer abandons the command: no done pulse and no further beats.

Structure
REQ-031 A shared package drm_pkg holds:
- DRM_ADDR_WIDTH=10, DRM_DATA_WIDTH=32
- the FSM state enum (IDLE, READ, DRAIN)
REQ-032 One sub-module: drm_rd_fifo, a synchronous FIFO of FIFO_DEPTH entries with push, pop, empty and count outputs.
REQ-033 The RAM macro is instantiated outside this block; only its read port is driven from here.

Verification
REQ-034 RAM preloaded with data[a]=0xFFFFFFFF-a. Command addr=0, len=1024, m_ready=1 -> 1024 beats 0xFFFFFFFF down to 0xFFFFFC00, m_last on the 1024th beat, done once.
REQ-035 Command addr=1022, len=4 -> beats from addresses 1022, 1023, 0, 1, i.e. data 0xFFFFFC01, 0xFFFFFC00, 0xFFFFFFFF, 0xFFFFFFFE.
REQ-036 Command addr=0, len=16, with m_ready toggled in a random pattern and held low for 20 cycles -> 16 beats in order, no loss or duplicate, m_data stable while stalled.
REQ-037 Command with len=0 -> no m_valid, done one cycle later, cmd_ready stays 1.
REQ-038 rd_rst asserted at beat 5 of a len=100 command -> m_valid=0 the next cycle, no done. A subsequent command addr=10, len=2 returns 0xFFFFFFF5, 0xFFFFFFF4.
REQ-039 Repeat REQ-034 with RD_LATENCY=2 -> identical data sequence and 1 beat/cycle throughput.
